// File: rtl/pid_term_calc.sv
// PID term calculator: turns one (setpoint, measurement) sample into ik, pk, dk.
// One shared signed multiplier is sequenced through the P, I and D products.
module pid_term_calc #(
    parameter int N    = 23,
    parameter int FRAC = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clr_int,
    input  logic signed [N-1:0] r,
    input  logic signed [N-1:0] y,
    input  logic signed [N-1:0] kp,
    input  logic signed [N-1:0] ki,
    input  logic signed [N-1:0] kd,
    output logic signed [N-1:0] ik,
    output logic signed [N-1:0] pk,
    output logic signed [N-1:0] dk,
    output logic                busy,
    output logic                done
);

    localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CALC, MUL_P, MUL_I, MUL_D, DONE
    } state_t;

    state_t state;

    logic signed [N-1:0] r_q, y_q, kp_q, ki_q, kd_q;
    logic signed [N-1:0] e, dy, p_int, i_acc, y_prev;
    logic                first;

    logic signed [N-1:0]   mul_a, mul_b, mul_sat;
    logic signed [2*N-1:0] prod;

    // Clamp an N+1 bit sum/difference into N bits.
    function automatic logic signed [N-1:0] sat_w(input logic signed [N:0] x);
        if (x[N] != x[N-1])
            sat_w = x[N] ? MINV : MAXV;
        else
            sat_w = x[N-1:0];
    endfunction

    // Rescale a full product by FRAC (floor) and clamp into N bits.
    function automatic logic signed [N-1:0] sat_p(input logic signed [2*N-1:0] p);
        logic signed [2*N-1:0] s;
        s = p >>> FRAC;
        if (&s[2*N-1:N-1] || ~|s[2*N-1:N-1])
            sat_p = s[N-1:0];
        else
            sat_p = s[2*N-1] ? MINV : MAXV;
    endfunction

    // Route the operands of the current product phase to the shared multiplier.
    always_comb begin
        mul_a = kp_q;
        mul_b = y_q;
        case (state)
            MUL_I: begin
                mul_a = ki_q;
                mul_b = e;
            end
            MUL_D: begin
                mul_a = kd_q;
                mul_b = dy;
            end
            default: begin
                mul_a = kp_q;
                mul_b = y_q;
            end
        endcase
    end

    assign prod    = {{N{mul_a[N-1]}}, mul_a} * {{N{mul_b[N-1]}}, mul_b};
    assign mul_sat = sat_p(prod);

    // Sequencer and datapath; the term set is loaded as one so it never mixes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            r_q    <= '0;
            y_q    <= '0;
            kp_q   <= '0;
            ki_q   <= '0;
            kd_q   <= '0;
            e      <= '0;
            dy     <= '0;
            p_int  <= '0;
            i_acc  <= '0;
            y_prev <= '0;
            first  <= 1'b1;
            ik     <= '0;
            pk     <= '0;
            dk     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_q   <= r;
                        y_q   <= y;
                        kp_q  <= kp;
                        ki_q  <= ki;
                        kd_q  <= kd;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    e  <= sat_w({r_q[N-1], r_q} - {y_q[N-1], y_q});
                    dy <= first ? '0
                                : sat_w({y_q[N-1], y_q} - {y_prev[N-1], y_prev});
                    state <= MUL_P;
                end
                MUL_P: begin
                    p_int <= mul_sat;
                    state <= MUL_I;
                end
                MUL_I: begin
                    i_acc <= sat_w({i_acc[N-1], i_acc} + {mul_sat[N-1], mul_sat});
                    state <= MUL_D;
                end
                MUL_D: begin
                    ik     <= i_acc;
                    pk     <= p_int;
                    dk     <= mul_sat;
                    y_prev <= y_q;
                    first  <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
            if (clr_int)
                i_acc <= '0;
        end
    end

endmodule

// File: tb/tb_pid_term_calc.sv
// Bench for pid_term_calc: directed corner samples plus randomized samples
// checked against an arithmetic model of the PID term rules.
module tb_pid_term_calc;

    localparam int     N    = 23;
    localparam longint MAXV = 4194303;
    localparam longint MINV = -4194304;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic clr_int;
    logic signed [N-1:0] r, y, kp, ki, kd;
    logic signed [N-1:0] ik, pk, dk;
    logic busy, done;

    int total = 0;
    int bad   = 0;

    longint m_iacc, m_yp;
    bit     m_first;
    longint e_ik, e_pk, e_dk;

    always #5 clk = ~clk;

    pid_term_calc #(.N(N), .FRAC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .clr_int(clr_int),
        .r(r), .y(y), .kp(kp), .ki(ki), .kd(kd),
        .ik(ik), .pk(pk), .dk(dk), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint mulq(input longint a, input longint b);
        longint p;
        p = a * b;
        return sat(p >>> 10);
    endfunction

    function automatic longint rv();
        longint x;
        if ($urandom_range(0, 3) == 0) begin
            x = longint'($urandom_range(0, 8388607));
            return x - 4194304;
        end
        x = longint'($urandom_range(0, 16384));
        return x - 8192;
    endfunction

    task automatic model_reset();
        m_iacc  = 0;
        m_yp    = 0;
        m_first = 1;
        e_ik    = 0;
        e_pk    = 0;
        e_dk    = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_busy", longint'(busy), 0);
            chk("idle_done", longint'(done), 0);
            chk("held_ik", longint'(ik), e_ik);
            chk("held_pk", longint'(pk), e_pk);
            chk("held_dk", longint'(dk), e_dk);
        end
    endtask

    // Call at a negedge while the DUT is IDLE or in its DONE cycle.
    // clr_c selects the busy cycle (1..4) in which clr_int is pulsed, 0 = none.
    task automatic do_sample(input longint vr, input longint vy,
                             input longint vkp, input longint vki,
                             input longint vkd, input int clr_c);
        longint ev, dyv, tv;
        longint p_ik, p_pk, p_dk;
        p_ik = e_ik;
        p_pk = e_pk;
        p_dk = e_dk;
        r  = N'(vr);
        y  = N'(vy);
        kp = N'(vkp);
        ki = N'(vki);
        kd = N'(vkd);
        start   = 1'b1;
        clr_int = 1'b0;
        ev  = sat(vr - vy);
        dyv = m_first ? 0 : sat(vy - m_yp);
        tv  = mulq(vki, ev);
        if (clr_c == 1 || clr_c == 2) m_iacc = 0;
        m_iacc = (clr_c == 3) ? 0 : sat(m_iacc + tv);
        e_ik = m_iacc;
        if (clr_c == 4) m_iacc = 0;
        e_pk    = mulq(vkp, vy);
        e_dk    = mulq(vkd, dyv);
        m_yp    = vy;
        m_first = 0;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("busy", longint'(busy), 1);
            chk("done", longint'(done), (c == 5) ? 1 : 0);
            if (c == 4) begin
                chk("mid_ik", longint'(ik), p_ik);
                chk("mid_pk", longint'(pk), p_pk);
                chk("mid_dk", longint'(dk), p_dk);
            end
            if (c == 5) begin
                chk("ik", longint'(ik), e_ik);
                chk("pk", longint'(pk), e_pk);
                chk("dk", longint'(dk), e_dk);
                start   = 1'b0;
                clr_int = 1'b0;
            end else begin
                start   = $urandom_range(0, 1) == 1;
                clr_int = (c == clr_c);
                r  = N'($urandom);
                y  = N'($urandom);
                kp = N'($urandom);
                ki = N'($urandom);
                kd = N'($urandom);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        clr_int = 1'b0;
        r  = '0;
        y  = '0;
        kp = '0;
        ki = '0;
        kd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ik", longint'(ik), 0);
        chk("rst_pk", longint'(pk), 0);
        chk("rst_dk", longint'(dk), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        reset = 1'b1;
        idle(1);

        // basic two-sample sequence
        do_sample(4096, 1024, 1024, 512, 2048, 0);
        idle(2);
        chk("t1_pk", longint'(pk), 1024);
        chk("t1_ik", longint'(ik), 1536);
        chk("t1_dk", longint'(dk), 0);
        do_sample(4096, 2048, 1024, 512, 2048, 0);
        idle(3);
        chk("t2_pk", longint'(pk), 2048);
        chk("t2_ik", longint'(ik), 2560);
        chk("t2_dk", longint'(dk), 2048);

        // clamping of products and the integrator
        do_sample(0, MAXV, MAXV, 0, 0, 0);
        chk("t3_pmax", longint'(pk), MAXV);
        do_sample(0, MINV, MAXV, 0, 0, 0);
        chk("t3_pmin", longint'(pk), MINV);
        idle(1);
        repeat (3) do_sample(MAXV, MINV, 0, MAXV, 0, 0);
        chk("t3_ipin", longint'(ik), MAXV);
        do_sample(0, 1024, 0, 1024, 0, 0);
        chk("t3_irec", longint'(ik), MAXV - 1024);
        idle(1);

        // back-to-back with start held high
        for (int k = 0; k < 4; k++)
            do_sample(rv(), rv(), rv(), rv(), rv(), 0);
        idle(2);

        // reset in the MUL_I cycle
        r  = N'(longint'(4096));
        y  = N'(longint'(1024));
        kp = N'(longint'(1024));
        ki = N'(longint'(512));
        kd = N'(longint'(2048));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_ik", longint'(ik), 0);
        chk("mr_pk", longint'(pk), 0);
        chk("mr_dk", longint'(dk), 0);
        chk("mr_busy", longint'(busy), 0);
        chk("mr_done", longint'(done), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        do_sample(3000, 500, 700, 300, 4096, 0);
        chk("mr_first_dk", longint'(dk), 0);
        idle(1);

        // integrator clear in the MUL_I cycle
        do_sample(4096, 1024, 1024, 512, 2048, 3);
        chk("clr_ik", longint'(ik), 0);
        idle(1);
        do_sample(4096, 1024, 1024, 512, 2048, 0);
        chk("clr_next_ik", longint'(ik), 1536);
        idle(1);

        // randomized samples, clears and gaps
        for (int k = 0; k < 60; k++) begin
            int cc;
            cc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_sample(rv(), rv(), rv(), rv(), rv(), cc);
            if ($urandom_range(0, 1) == 1)
                idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
